// File: rtl/aes_inv_key_sched_128.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_key_sched_128 (with sbox primitive)
// Brief    : AES-128 decryption key scheduler. Expands the cipher key forward
//            to round key 10, then streams round keys 10..0 over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================

// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map
module sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  logic [7:0] w_x2, w_x3, w_x12, w_x15, w_x240, w_x254;

  // x^254 equals x^-1 for nonzero x and maps 0 to 0
  always_comb begin
    w_x2   = gf_mul(i_byte, i_byte);
    w_x3   = gf_mul(w_x2, i_byte);
    w_x12  = gf_mul(gf_mul(w_x3, w_x3), gf_mul(w_x3, w_x3));
    w_x15  = gf_mul(w_x12, w_x3);
    w_x240 = gf_mul(gf_mul(gf_mul(w_x15, w_x15), gf_mul(w_x15, w_x15)),
                    gf_mul(gf_mul(w_x15, w_x15), gf_mul(w_x15, w_x15)));
    w_x240 = gf_mul(w_x240, w_x240);
    w_x254 = gf_mul(gf_mul(w_x240, w_x12), w_x2);
    o_byte = w_x254 ^ rotl(w_x254, 1) ^ rotl(w_x254, 2) ^ rotl(w_x254, 3)
             ^ rotl(w_x254, 4) ^ 8'h63;
  end
endmodule

module aes_inv_key_sched_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FWD  = 2'd1;
  localparam logic [1:0] c_REV  = 2'd2;

  logic [1:0]   r_state, w_state_nxt;
  logic [127:0] r_kr, w_kr_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic         r_done, w_done_nxt;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_sb_in, w_rot, w_sub, w_t;
  logic [3:0]   w_rcon_idx;
  logic [7:0]   w_rcon;
  logic [127:0] w_fwd, w_inv;
  logic         w_xfer;

  assign {w_w0, w_w1, w_w2, w_w3} = r_kr;

  // In REV the last word of the previous round key is recovered as w3^w2
  assign w_sb_in = (r_state == c_REV) ? (w_w3 ^ w_w2) : w_w3;
  assign w_rot   = {w_sb_in[23:0], w_sb_in[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sbox u_sbox (
        .i_byte (w_rot[8*gi +: 8]),
        .o_byte (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  // Forward step uses rcon of the round being produced, reverse uses the current one
  assign w_rcon_idx = (r_state == c_FWD) ? (r_rnd + 4'd1) : r_rnd;

  // Round constant lookup
  always_comb begin
    case (w_rcon_idx)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_t = w_sub ^ {w_rcon, 24'h000000};

  // Forward and inverse single-round key transforms
  always_comb begin
    w_fwd[127:96] = w_w0 ^ w_t;
    w_fwd[95:64]  = w_fwd[127:96] ^ w_w1;
    w_fwd[63:32]  = w_fwd[95:64] ^ w_w2;
    w_fwd[31:0]   = w_fwd[63:32] ^ w_w3;
    w_inv[31:0]   = w_w3 ^ w_w2;
    w_inv[63:32]  = w_w2 ^ w_w1;
    w_inv[95:64]  = w_w1 ^ w_w0;
    w_inv[127:96] = w_w0 ^ w_t;
  end

  assign w_xfer = (r_state == c_REV) && rk_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_kr    <= '0;
      r_rnd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kr    <= w_kr_nxt;
      r_rnd   <= w_rnd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_kr_nxt    = r_kr;
    w_rnd_nxt   = r_rnd;
    w_done_nxt  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_state_nxt = c_FWD;
          w_kr_nxt    = key;
          w_rnd_nxt   = 4'd0;
        end
      end
      c_FWD: begin
        w_kr_nxt  = w_fwd;
        w_rnd_nxt = r_rnd + 4'd1;
        if (r_rnd == 4'd9) w_state_nxt = c_REV;
      end
      c_REV: begin
        if (w_xfer) begin
          if (r_rnd != 4'd0) begin
            w_kr_nxt  = w_inv;
            w_rnd_nxt = r_rnd - 4'd1;
          end else begin
            w_state_nxt = c_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs are decoded from registers only
  always_comb begin
    busy     = (r_state != c_IDLE);
    rk_valid = (r_state == c_REV);
    rk       = rk_valid ? r_kr : '0;
    rk_round = rk_valid ? r_rnd : 4'd0;
    done     = r_done;
  end
endmodule
`default_nettype wire
